// File: rtl/marin_uart_rx_pkg.sv
// rtl/marin_uart_rx_pkg.sv - shared types and constants for the Marin UART receiver
package marin_uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  localparam logic [1:0] DATA_OFS = 2'd0;
  localparam logic [1:0] STAT_OFS = 2'd2;

  localparam int STAT_NEMPTY = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_OVR    = 2;
  localparam int STAT_FERR   = 3;
  localparam int STAT_PERR   = 4;

endpackage

// File: rtl/marin_uart_rx_fifo.sv
// rtl/marin_uart_rx_fifo.sv - 8-bit first-word-fall-through FIFO, depth 2**FIFO_AW
module marin_uart_rx_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_empty,
  output logic       o_full
);

  logic [7:0]       r_mem [2**FIFO_AW];
  logic [FIFO_AW:0] r_wr;
  logic [FIFO_AW:0] r_rd;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[FIFO_AW] != r_rd[FIFO_AW]) &&
                     (r_wr[FIFO_AW-1:0] == r_rd[FIFO_AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd[FIFO_AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr[FIFO_AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/marin_uart_rx.sv
// rtl/marin_uart_rx.sv - Wishbone UART receiver with RX FIFO; MARIN_UART_RX_PARITY_EN adds 8E1 parity
module marin_uart_rx
  import marin_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [31:0] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  input  logic        rx_i,
  output logic        irq_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1, r_sync2, r_rx_d;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_rx, w_expire;
  logic          w_push_req, w_ferr_set, w_perr_set;
  logic          r_ack, r_ovr, r_ferr, r_perr, r_irq;
  logic [15:0]   r_dat;
  logic          w_req, w_sel_stat, w_sel_data, w_pop, w_clr;
  logic          w_empty, w_full, w_ovr_set;
  logic [7:0]    w_head;
  logic [15:0]   w_status;
  logic          w_unused;
`ifdef MARIN_UART_RX_PARITY_EN
  logic          r_par_bad, w_par_bad_nxt;
`endif

  assign w_unused = ^{wb_sel_i, wb_adr_i[31:2], wb_adr_i[0], wb_dat_i[15:4], wb_dat_i[1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  assign w_rx     = r_sync2;
  assign w_expire = (r_cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
`ifdef MARIN_UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
`ifdef MARIN_UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_expire ? r_cnt : r_cnt - 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push_req  = 1'b0;
    w_ferr_set  = 1'b0;
    w_perr_set  = 1'b0;
`ifdef MARIN_UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
`endif
    case (r_state)
      ST_IDLE: begin
        if (r_rx_d && !w_rx) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = HALF_BIT;
        end
      end
      ST_START: begin
        if (w_expire) begin
          if (!w_rx) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = FULL_BIT;
            w_bit_nxt   = 3'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (w_expire) begin
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_cnt_nxt   = FULL_BIT;
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == 3'd7) begin
`ifdef MARIN_UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef MARIN_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_expire) begin
          w_par_bad_nxt = w_rx ^ (^r_shift);
          w_cnt_nxt     = FULL_BIT;
          w_state_nxt   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_expire) begin
          if (w_rx) begin
            w_state_nxt = ST_IDLE;
`ifdef MARIN_UART_RX_PARITY_EN
            w_push_req  = !r_par_bad;
            w_perr_set  = r_par_bad;
`else
            w_push_req  = 1'b1;
`endif
          end else begin
            w_state_nxt = ST_WAIT_HIGH;
            w_ferr_set  = 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (w_rx) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  marin_uart_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_data  (w_shift_nxt),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Pop and flag clears commit on the edge that raises ack, so they are visible in the ack cycle.
  assign w_req      = wb_cyc_i && wb_stb_i && !r_ack;
  assign w_sel_stat = (wb_adr_i[1] == STAT_OFS[1]);
  assign w_sel_data = (wb_adr_i[1] == DATA_OFS[1]);
  assign w_pop      = w_req && !wb_we_i && w_sel_data && !w_empty;
  assign w_clr      = w_req && wb_we_i && w_sel_stat;
  assign w_ovr_set  = w_push_req && w_full && !w_pop;

  always_comb begin
    w_status              = '0;
    w_status[STAT_NEMPTY] = !w_empty;
    w_status[STAT_FULL]   = w_full;
    w_status[STAT_OVR]    = r_ovr;
    w_status[STAT_FERR]   = r_ferr;
`ifdef MARIN_UART_RX_PARITY_EN
    w_status[STAT_PERR]   = r_perr;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_ack <= w_req;
      if (w_req) begin
        if (wb_we_i)         r_dat <= '0;
        else if (w_sel_stat) r_dat <= w_status;
        else if (!w_empty)   r_dat <= {8'h00, w_head};
        else                 r_dat <= '0;
      end
      r_ovr  <= w_ovr_set  || (r_ovr  && !(w_clr && wb_dat_i[STAT_OVR]));
      r_ferr <= w_ferr_set || (r_ferr && !(w_clr && wb_dat_i[STAT_FERR]));
`ifdef MARIN_UART_RX_PARITY_EN
      r_perr <= w_perr_set || (r_perr && !(w_clr && wb_dat_i[STAT_PERR]));
`else
      r_perr <= w_perr_set;
`endif
      r_irq  <= !w_empty;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_irq;

endmodule

// File: tb/tb_marin_uart_rx.sv
// tb/tb_marin_uart_rx.sv - directed bench for marin_uart_rx against a frame-level model
module tb_marin_uart_rx;

  localparam int CPB = 16;
  localparam logic [31:0] A_DATA = 32'hF000_0010;
  localparam logic [31:0] A_STAT = 32'hF000_0012;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic [31:0] wb_adr_i = '0;
  logic [1:0]  wb_sel_i = 2'b11;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_ack_o;
  logic        rx = 1'b1;
  logic        irq_o;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  model_q[$];
  bit          m_ovr, m_ferr, m_perr;
  logic [15:0] exp_dat;
  bit          exp_chk = 0;
  bit          settled = 0;
  logic [15:0] q;

  always #5 clk = ~clk;

  marin_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut (
    .clk_i(clk), .rst_i(rst), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .rx_i(rx), .irq_o(irq_o)
  );

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s = '0;
    s[0] = (model_q.size() != 0);
    s[1] = (model_q.size() == 16);
    s[2] = m_ovr;
    s[3] = m_ferr;
    s[4] = m_perr;
    return s;
  endfunction

  always @(negedge clk) begin
    if (wb_ack_o && exp_chk) chk("wb_dat", wb_dat_o, exp_dat);
    if (settled) chk("irq", {15'b0, irq_o}, {15'b0, (model_q.size() != 0)});
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [31:0] adr, input bit we, input logic [15:0] d, output logic [15:0] r);
    int n;
    @(posedge clk); #1;
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = d; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wb_ack_o && n < 8) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!wb_ack_o) begin
      errors++;
      $display("FAIL wb_ack: got 0 expected 1 at %0t", $time);
    end
    r = wb_dat_o;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic read_data(output logic [15:0] r);
    settled = 0;
    exp_dat = (model_q.size() != 0) ? {8'h00, model_q[0]} : 16'h0000;
    exp_chk = 1;
    wb(A_DATA, 1'b0, 16'h0, r);
    exp_chk = 0;
    if (model_q.size() != 0) void'(model_q.pop_front());
    repeat (3) @(posedge clk);
    #1;
    settled = 1;
  endtask

  task automatic read_status(output logic [15:0] r);
    exp_dat = model_status();
    exp_chk = 1;
    wb(A_STAT, 1'b0, 16'h0, r);
    exp_chk = 0;
  endtask

  task automatic write_status(input logic [15:0] d);
    logic [15:0] dummy;
    wb(A_STAT, 1'b1, d, dummy);
    if (d[2]) m_ovr = 0;
    if (d[3]) m_ferr = 0;
    if (d[4]) m_perr = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_bit);
    bit par_ok;
    settled = 0;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    par_ok = 1;
`ifdef MARIN_UART_RX_PARITY_EN
    drive(par_bit, CPB);
    par_ok = (par_bit == ^b);
`endif
    drive(stop_ok, CPB);
    if (!stop_ok)          m_ferr = 1;
    else if (!par_ok)      m_perr = 1;
    else if (model_q.size() == 16) m_ovr = 1;
    else                   model_q.push_back(b);
    if (stop_ok) drive(1'b1, 4);
    settled = 1;
  endtask

  initial begin
    m_ovr = 0; m_ferr = 0; m_perr = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {15'b0, wb_ack_o}, 16'h0);
    chk("rst_dat", wb_dat_o, 16'h0);
    chk("rst_irq", {15'b0, irq_o}, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 4);
    settled = 1;
    read_status(q);
    chk("lit_status_reset", q, 16'h0000);

    send_frame(8'hA5, 1, 1'b0);
    read_status(q);
    chk("lit_status_a5", q, 16'h0001);
    chk("lit_irq_a5", {15'b0, irq_o}, 16'h0001);
    read_data(q);
    chk("lit_data_a5", q, 16'h00A5);
    read_status(q);
    chk("lit_status_drained", q, 16'h0000);
    chk("lit_irq_drained", {15'b0, irq_o}, 16'h0000);

    for (int i = 0; i <= 16; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_frame(b, 1, ^b);
    end
    read_status(q);
    chk("lit_status_ovr", q, 16'h0007);
    for (int i = 0; i < 16; i++) begin
      read_data(q);
      chk("lit_data_seq", q, 16'(i));
    end
    read_data(q);
    chk("lit_data_empty", q, 16'h0000);
    write_status(16'h0004);
    read_status(q);
    chk("lit_status_ovr_clr", q, 16'h0000);

    send_frame(8'h55, 0, ^8'h55);
    drive(1'b0, 40 * CPB);
    read_status(q);
    chk("lit_status_ferr", q, 16'h0008);
    drive(1'b1, 2 * CPB);
    send_frame(8'h3C, 1, ^8'h3C);
    read_status(q);
    chk("lit_status_3c", q, 16'h0009);
    read_data(q);
    chk("lit_data_3c", q, 16'h003C);
    write_status(16'h001C);

    settled = 0;
    drive(1'b0, CPB / 4);
    drive(1'b1, 3 * CPB);
    settled = 1;
    read_status(q);
    chk("lit_status_glitch", q, 16'h0000);

    send_frame(8'h11, 1, ^8'h11);
    settled = 0;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'b0, CPB);
    drive(1'b1, CPB / 2);
    rst = 1'b1;
    model_q.delete();
    m_ovr = 0; m_ferr = 0; m_perr = 0;
    drive(1'b1, 2);
    chk("midrst_ack", {15'b0, wb_ack_o}, 16'h0);
    chk("midrst_dat", wb_dat_o, 16'h0);
    chk("midrst_irq", {15'b0, irq_o}, 16'h0);
    rst = 1'b0;
    drive(1'b1, 3 * CPB);
    settled = 1;
    read_status(q);
    chk("lit_status_midrst", q, 16'h0000);
    send_frame(8'h5A, 1, ^8'h5A);
    read_data(q);
    chk("lit_data_5a", q, 16'h005A);

`ifdef MARIN_UART_RX_PARITY_EN
    send_frame(8'h07, 1, 1'b1);
    read_data(q);
    chk("lit_data_par_ok", q, 16'h0007);
    send_frame(8'h07, 1, 1'b0);
    read_status(q);
    chk("lit_status_perr", q, 16'h0010);
    write_status(16'h0010);
    read_status(q);
    chk("lit_status_perr_clr", q, 16'h0000);
`endif

    settled = 0;
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/marin_uart_rx.md
# marin_uart_rx

Wishbone-slave UART receiver for the Marin SoC.
- Deserialises 8N1 (optionally 8E1) frames from `rx_i` and buffers received bytes in a small FIFO.
- Sits on the 16-bit Wishbone bus at 0xF0000010 (mask 0xFFFFFFFC) alongside the display, PIC and PIT.
- The CPU drains the FIFO by reading it; it is the receive-side counterpart to the transmit-only path that drives `tx_o`.
- `irq_o` feeds one line of the PIC.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clk_i cycles per bit (50 MHz / 115200); must be ≥ 8.
- `FIFO_AW`, 4: log2 FIFO depth (16 bytes).

Ports:
- `clk_i` in 1: single clock; all logic on rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `wb_dat_i` in 16: write data.
- `wb_dat_o` out 16: read data.
- `wb_adr_i` in 32: byte address; only bit 1 decoded.
- `wb_sel_i` in 2: ignored.
- `wb_we_i` in 1: write enable.
- `wb_cyc_i` in 1: cycle.
- `wb_stb_i` in 1: strobe.
- `wb_ack_o` out 1: acknowledge.
- `rx_i` in 1: serial input, idle high, asynchronous to clk_i.
- `irq_o` out 1: level interrupt, high while FIFO non-empty.

## Operation
- `rx_i` passes through a 2-flop synchroniser (reset value 1) before any use.
- Receive FSM states:
  - IDLE: a falling edge on the synchronised rx → START, and the bit counter loads CLKS_PER_BIT/2−1.
  - START: at counter 0, sample. Low → DATA with the counter reloaded to CLKS_PER_BIT−1. High → glitch; return to IDLE with nothing recorded.
  - DATA: sample at each counter expiry and shift in LSB first. After 8 bits go to PARITY if compiled in, else STOP.
  - STOP: sample. High → push byte. Low → set `ferr`, discard byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronised rx is high, then IDLE. This handles break conditions.
- Push: occurs in the cycle after the stop sample. If the FIFO is full, the byte is dropped and `ovr` is set; FIFO contents are unchanged.
- Register map (16-bit, data in [7:0], unused bits read 0):
  - Offset 0 DATA. Read returns the head byte and pops it. Read when empty returns 0x0000 with no pop. Writes are acknowledged and ignored.
  - Offset 2 STATUS:
    - bit0 not-empty, bit1 full, bit2 `ovr` (sticky), bit3 `ferr` (sticky), bit4 `perr` (sticky, parity build only).
    - Writing 1 to bits 2–4 clears them.
    - If a clear coincides with a set event, the set wins.
- Simultaneous push and pop: both take effect, count unchanged. A pop on a full FIFO in the same cycle as a push is not an overrun.
- `irq_o` = registered not-empty.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `irq_o`=0, FSM=IDLE, FIFO empty, sticky flags 0.
- Reset asserted mid-frame aborts the frame with no push and no error flagged.
- Ack: registered. `wb_ack_o` rises the cycle after `cyc&stb&!ack` and is held one cycle.
  - A continuously held stb therefore gets an ack every second cycle.
  - `wb_dat_o` is valid in the ack cycle.
- The pop and the flag clear both take effect in the ack cycle.
- Latency:
  - Stop-bit mid-sample to not-empty is visible in STATUS within 1 cycle.
  - `irq_o` asserts 2 cycles after the stop sample.
- Synchroniser latency is 2 cycles.
- Sampling point error is ≤ 1 clk_i cycle from nominal mid-bit.

## Configuration
- `MARIN_UART_RX_PARITY_EN` defined:
  - PARITY state follows DATA and samples one even-parity bit.
  - On mismatch, the byte is discarded after a valid stop bit and `perr` is set.
  - STATUS bit4 is live.
- Not defined: 8N1 only, no PARITY state, and STATUS bit4 reads 0.

## Structure
- `marin_uart_rx_pkg`: FSM state enum, register offsets (`DATA_OFS`=0, `STAT_OFS`=2), STATUS bit index constants.
- Sub-module `marin_uart_rx_fifo`:
  - Synchronous FIFO, 8-bit wide, depth 2^FIFO_AW.
  - Ports: push, pop, data, empty, full.
  - Pointers are FIFO_AW+1 bits with wrap-bit full/empty detection.
  - Head data is shown combinationally (first-word fall-through).

## Test plan
- Frame 0xA5 at CLKS_PER_BIT=16 → STATUS reads 0x0001, `irq_o`=1; DATA reads 0x00A5; STATUS then reads 0x0000 and `irq_o`=0.
- 17 frames 0x00..0x10 with no reads → STATUS 0x0007 (bits 0–2); 16 DATA reads return 0x00..0x0F in order; writing 0x0004 to STATUS clears `ovr`.
- Frame with stop bit low, then line held low 40 bit-times → `ferr` set, FIFO empty, FSM stays in WAIT_HIGH; after release, a following 0x3C frame is received correctly.
- Low pulse of CLKS_PER_BIT/4 cycles → no push, no flags set.
- `rst_i` pulsed during bit 4 of a frame → all outputs return to reset values, no byte pushed; the next full frame is received correctly.
- With `MARIN_UART_RX_PARITY_EN`: 0x07 sent with parity 1 → byte received; 0x07 sent with parity 0 → `perr` set and STATUS reads 0x0010.
